// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-side arbiter and its helpers:
//   state_t        - arbiter FSM encoding (IDLE / BURST)
//   DEPTH_BIT_DEF  - default FIFO address width
//   DEPTH_MAX_DEF  - default usable FIFO entries (one slot kept free)
//   clog2()        - ceil-log2 sizing helper, never returns less than 1
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEPTH_BIT_DEF = 4;
  localparam int DEPTH_MAX_DEF = 15;

  // Bits needed to encode the values 0 .. value-1, at least one bit so a
  // degenerate parameter still yields a legal vector.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder.
//   req         in  NREQ   request vector, bit k = requester k
//   last_winner in  IDX_W  index of the previous winner
//   gnt         out NREQ   one-hot winner, zero when nothing requests
//   valid       out 1      at least one request present
// The search starts at last_winner+1 and wraps, so the previous winner
// has the lowest priority this round.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  // Modulo on the integer index keeps the wrap correct even when NREQ is
  // not a power of two.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && req[(int'(last_winner) + i) % NREQ]) begin
        gnt[(int'(last_winner) + i) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares one FIFO write port among NREQ requesters with round-robin
// arbitration and burst locking, and owns the FIFO write pointer.
//   i_clk    in  1            clock, rising edge
//   i_rest   in  1            synchronous active-high reset
//   i_req    in  NREQ         per-requester write request
//   i_last   in  NREQ         per-requester last-beat marker
//   i_data   in  NREQ*DATA_W  requester k data at [k*DATA_W +: DATA_W]
//   i_addrr  in  DEPTH_BIT    FIFO read pointer from the read side
//   o_gnt    out NREQ         registered one-hot grant
//   o_ack    out NREQ         combinational beat-accept strobe
//   o_wen    out 1            registered FIFO write enable
//   o_wdata  out DATA_W       registered FIFO write data
//   o_addrw  out DEPTH_BIT    registered FIFO write address
//   o_full   out 1            combinational full flag
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH_BIT = DEPTH_BIT_DEF,
  parameter int DEPTH_MAX = DEPTH_MAX_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rest,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_last,
  input  logic [NREQ*DATA_W-1:0] i_data,
  input  logic [DEPTH_BIT-1:0]   i_addrr,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_ack,
  output logic                   o_wen,
  output logic [DATA_W-1:0]      o_wdata,
  output logic [DEPTH_BIT-1:0]   o_addrw,
  output logic                   o_full
);

  localparam int IDX_W = clog2(NREQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);

  state_t               state_q, state_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [DEPTH_BIT-1:0] wptr_q, wptr_d;
  logic                 wen_q, wen_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DEPTH_BIT-1:0] addrw_q, addrw_d;

  logic [NREQ-1:0]      pick_gnt;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [DEPTH_BIT-1:0] occupancy;
  logic                 full;
  logic                 cur_req;
  logic                 cur_last;
  logic [DATA_W-1:0]    cur_data;
  logic                 accept;
  logic [CNT_W-1:0]     beat_inc;
  logic                 terminate;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (i_req),
    .last_winner (last_q),
    .gnt         (pick_gnt),
    .valid       (pick_valid)
  );

  // The winner index is kept alongside the one-hot grant so the data mux
  // and the round-robin history need no encoder on the critical path.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  // wptr already includes an accepted beat that is still in the output
  // register, so the full flag never lets an in-flight write be overrun.
  always_comb begin
    occupancy = wptr_q - i_addrr;
    full      = (occupancy == DEPTH_BIT'(DEPTH_MAX));
  end

  always_comb begin
    cur_req   = i_req[idx_q];
    cur_last  = i_last[idx_q];
    cur_data  = i_data[int'(idx_q) * DATA_W +: DATA_W];
    accept    = (state_q == BURST) && !i_rest && cur_req && !full;
    beat_inc  = beat_q + 1'b1;
    terminate = !cur_req ||
                (accept && (cur_last || (beat_inc == CNT_W'(MAX_BURST))));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    beat_d  = beat_q;
    wptr_d  = wptr_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    addrw_d = addrw_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (accept) begin
          wen_d   = 1'b1;
          wdata_d = cur_data;
          addrw_d = wptr_q;
          wptr_d  = wptr_q + 1'b1;
          beat_d  = beat_inc;
        end
        // A full stall keeps the grant; only the requester dropping its
        // request, its last beat, or the burst limit releases it.
        if (terminate) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Reset also clears wen, so a write accepted on the reset edge is lost.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      beat_q  <= '0;
      wptr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      addrw_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      addrw_q <= addrw_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_ack   = accept ? gnt_q : '0;
  assign o_wen   = wen_q;
  assign o_wdata = wdata_q;
  assign o_addrw = addrw_q;
  assign o_full  = full;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one FIFO among NREQ requesters, using round-robin arbitration with burst locking.
- Owns the FIFO write pointer. Takes the read pointer from the read side and computes its own full condition, so in-flight writes are never overrun.
- Sits in front of the FIFO storage and the full/empty flag logic, alongside the read-side sequencer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, data width per requester.
- DEPTH_BIT, 4, FIFO address width.
- DEPTH_MAX, 15, usable FIFO entries; must equal 2**DEPTH_BIT-1 (one slot reserved).
- MAX_BURST, 4, maximum beats per grant (1..2**DEPTH_BIT).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rest  in  1  synchronous active-high reset.
- i_req  in  NREQ  per-requester write request; bit k = requester k.
- i_last  in  NREQ  per-requester last-beat marker, sampled with the beat.
- i_data  in  NREQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W].
- i_addrr  in  DEPTH_BIT  current FIFO read pointer.
- o_gnt  out  NREQ  one-hot registered grant; all zero when idle.
- o_ack  out  NREQ  combinational beat-accept strobe, one-hot or zero.
- o_wen  out  1  registered FIFO write enable.
- o_wdata  out  DATA_W  registered FIFO write data.
- o_addrw  out  DEPTH_BIT  registered FIFO write address for the o_wen cycle.
- o_full  out  1  combinational: (wptr - i_addrr) mod 2**DEPTH_BIT == DEPTH_MAX.

Behaviour:
- Reset (sampled at a rising edge of i_clk with i_rest=1):
  - state=IDLE, o_gnt=0, o_wen=0, o_wdata=0, o_addrw=0, wptr=0, beat count=0.
  - last_winner=NREQ-1, so requester 0 has first priority.
  - o_ack=0 while in reset.
  - Reset mid-burst discards the burst with no further writes. A write already registered is dropped, because o_wen is cleared on that edge.
- State IDLE:
  - If any i_req bit is set, the winner is the first set bit searching upward from last_winner+1 with wrap.
  - Next cycle: o_gnt=onehot(winner), state=BURST, beat count=0.
  - No accept is possible in IDLE, so there is a minimum one-cycle arbitration gap between bursts.
- State BURST, granted requester k:
  - o_ack[k]=1 iff i_req[k]=1 and o_full=0. Accept means one beat is taken.
  - On accept, next cycle: o_wen=1, o_wdata=i_data[k], o_addrw=wptr, wptr=wptr+1 mod 2**DEPTH_BIT, beat count +1.
  - Write latency from accept to o_wen is 1 cycle. At most one write per cycle.
  - wptr advances at accept, so o_full accounts for the in-flight write.
- Burst termination, checked in each BURST cycle:
  - Terminate on an accepted beat with i_last[k]=1, or an accepted beat that makes the count equal MAX_BURST, or i_req[k]=0.
  - On termination: state=IDLE, o_gnt=0, last_winner=k.
- o_full=1 during BURST: no accept, the grant is held, the burst stalls with no timeout.
  - Requesters must keep i_req[k] asserted to keep the grant.
  - Dropping i_req[k] during the stall ends the burst.
- Other requests arriving during BURST are ignored until return to IDLE.
- A single requester may win back-to-back bursts only when no other request is present in IDLE.
- Pointer arithmetic is DEPTH_BIT-wide modulo, so wrap 15→0 (default) is seamless.
- o_wen is a single-cycle pulse per beat. o_wdata and o_addrw hold their last values when o_wen=0.

Decomposition:
- Shared package holds: state encoding (IDLE=1'b0, BURST=1'b1), DEPTH_BIT/DEPTH_MAX defaults, and a ceil-log2 constant function for the beat counter and winner index widths.
- One natural sub-module: rr_pick, a combinational round-robin priority encoder.
  - Inputs: request vector, last_winner.
  - Outputs: one-hot winner, valid.
  - Reused later by the read-side scheduler.

Test Plan:
- Reset, then i_req=4'b0001, i_last[0] on 3rd beat, data 0xA1,0xA2,0xA3.
  - o_gnt=0001 one cycle after the request.
  - o_wen pulses with addr 0,1,2 and matching data.
  - o_gnt=0 after the 3rd accept.
- i_req=4'b1111 held, never i_last.
  - Grants go 0,1,2,3,0 with 4 beats each (MAX_BURST).
  - One idle cycle between grants.
  - Addresses increment contiguously and wrap 15→0.
- i_addrr fixed at 0, single requester streaming.
  - Exactly 15 accepts, then o_full=1 and o_ack=0 with the grant held.
  - Set i_addrr=1: one more accept at address 15.
- Mid-burst i_req[k] deasserted while full.
  - Burst ends with no write. Next arbitration starts from k+1.
- Assert i_rest for one cycle in BURST right after an accept.
  - Next cycle all outputs are 0, the pending write is dropped, and wptr=0.
  - The next grant goes to requester 0 if requesting.
- Simultaneous request from requesters 1 and 3 with last_winner=1.
  - Requester 3 wins, then requester 1.
